// File: rtl/decoder_sweep_checker_pkg.sv
// Shared definitions for the decoder sweep checker: FSM states, MISR
// constants and bus widths.
package dsc_pkg;

    localparam int unsigned IDX_W = 14;
    localparam int unsigned VEC_W = 130;
    localparam int unsigned CNT_W = 15;

    localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] SIG_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/decoder_sweep_checker_if.sv
// Beat bus between a decoder enumerator (master) and the sweep checker (slave).
interface decoder_sweep_checker_if;
    import dsc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [VEC_W-1:0] in_vec;

    modport master (output in_valid, output in_idx, output in_vec, input in_ready);
    modport slave  (input in_valid, input in_idx, input in_vec, output in_ready);

endinterface

// File: rtl/decoder_sweep_checker_misr.sv
// One MISR step: fold the 130-bit decoder vector and its index into 32 bits,
// then advance the CRC-32 style LFSR. Purely combinational.
module dsc_misr_step
    import dsc_pkg::*;
(
    input  logic [31:0]      i_sig,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [VEC_W-1:0] i_vec,
    output logic [31:0]      o_sig
);

    logic [31:0] w_fold;

    // Fold the vector into one word and shift the signature by one LFSR step
    always_comb begin
        w_fold = i_vec[31:0] ^ i_vec[63:32] ^ i_vec[95:64] ^ i_vec[127:96]
               ^ {i_vec[129:128], 16'h0000, i_idx};
        o_sig  = {i_sig[30:0], 1'b0} ^ (i_sig[31] ? SIG_POLY : '0) ^ w_fold;
    end

endmodule

// File: rtl/decoder_sweep_checker.sv
// Decoder sweep checker: accepts SWEEP_LEN beats after a start pulse, checks
// that indices arrive in order and compresses all vectors into a MISR
// signature. Optional macro DSC_FIRST_ERR_EN enables capture of the expected
// index at the first sequence error.
module decoder_sweep_checker
    import dsc_pkg::*;
#(
    parameter int unsigned SWEEP_LEN = 16384
) (
    input  logic                       CLK,
    input  logic                       RES,
    input  logic                       start,
    decoder_sweep_checker_if.slave     sink,
    output logic                       busy,
    output logic                       done,
    output logic                       seq_err,
    output logic [CNT_W-1:0]           count,
    output logic [31:0]                signature,
    output logic [IDX_W-1:0]           first_err_idx,
    output logic                       first_err_valid
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(SWEEP_LEN);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_sig;
    logic [IDX_W-1:0]   r_exp;
    logic               r_seq_err;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_mismatch;
    logic [31:0]        w_next_sig;

    assign w_ready    = (r_state == ST_RUN) & ~start;
    assign w_accept   = sink.in_valid & w_ready;
    assign w_last     = (r_count == LEN_C - CNT_W'(1));
    assign w_mismatch = (sink.in_idx != r_exp);

    dsc_misr_step u_misr (
        .i_sig (r_sig),
        .i_idx (sink.in_idx),
        .i_vec (sink.in_vec),
        .o_sig (w_next_sig)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: start wins everywhere; the final accepted beat ends the sweep
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = ST_RUN;
        end else if (r_state == ST_RUN && w_accept && w_last) begin
            w_next_state = ST_DONE;
        end
    end

    // Sweep datapath: clear on start, update only on accepted beats
    always_ff @(posedge CLK) begin
        if (RES || start) begin
            r_count   <= '0;
            r_sig     <= SIG_SEED;
            r_exp     <= '0;
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            r_count   <= r_count + CNT_W'(1);
            r_sig     <= w_next_sig;
            r_exp     <= r_exp + IDX_W'(1);
            r_seq_err <= r_seq_err | w_mismatch;
        end
    end

`ifdef DSC_FIRST_ERR_EN
    logic [IDX_W-1:0] r_first_idx;
    logic             r_first_valid;

    // Latch the expected index of the first mismatching beat only
    always_ff @(posedge CLK) begin
        if (RES || start) begin
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else if (w_accept && w_mismatch && !r_first_valid) begin
            r_first_idx   <= r_exp;
            r_first_valid <= 1'b1;
        end
    end

    assign first_err_idx   = r_first_idx;
    assign first_err_valid = r_first_valid;
`else
    assign first_err_idx   = '0;
    assign first_err_valid = 1'b0;
`endif

    assign sink.in_ready = w_ready;
    assign busy          = (r_state == ST_RUN);
    assign done          = (r_state == ST_DONE);
    assign seq_err       = r_seq_err;
    assign count         = r_count;
    assign signature     = r_sig;

endmodule

// File: tb/tb_decoder_sweep_checker.sv
// Scoreboard bench for decoder_sweep_checker: three instances (default,
// SWEEP_LEN=1, SWEEP_LEN=4). The driver pushes the expected post-beat state on
// every accepted beat; a monitor pops and compares one cycle later.
module tb_decoder_sweep_checker;
    import dsc_pkg::*;

`ifdef DSC_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RES;
    logic [2:0] st;

    always #5 CLK = ~CLK;

    decoder_sweep_checker_if b0 ();
    decoder_sweep_checker_if b1 ();
    decoder_sweep_checker_if b4 ();

    logic [2:0]       busy, done, seq, fev;
    logic [CNT_W-1:0] cnt [3];
    logic [31:0]      sig [3];
    logic [IDX_W-1:0] fei [3];

    decoder_sweep_checker u0 (
        .CLK(CLK), .RES(RES), .start(st[0]), .sink(b0.slave),
        .busy(busy[0]), .done(done[0]), .seq_err(seq[0]), .count(cnt[0]),
        .signature(sig[0]), .first_err_idx(fei[0]), .first_err_valid(fev[0])
    );

    decoder_sweep_checker #(.SWEEP_LEN(1)) u1 (
        .CLK(CLK), .RES(RES), .start(st[1]), .sink(b1.slave),
        .busy(busy[1]), .done(done[1]), .seq_err(seq[1]), .count(cnt[1]),
        .signature(sig[1]), .first_err_idx(fei[1]), .first_err_valid(fev[1])
    );

    decoder_sweep_checker #(.SWEEP_LEN(4)) u4 (
        .CLK(CLK), .RES(RES), .start(st[2]), .sink(b4.slave),
        .busy(busy[2]), .done(done[2]), .seq_err(seq[2]), .count(cnt[2]),
        .signature(sig[2]), .first_err_idx(fei[2]), .first_err_valid(fev[2])
    );

    // Reference MISR step shared with the design
    logic [31:0]      m_sig, m_next;
    logic [IDX_W-1:0] cur_idx;
    logic [VEC_W-1:0] cur_vec;

    dsc_misr_step m_step (
        .i_sig(m_sig), .i_idx(cur_idx), .i_vec(cur_vec), .o_sig(m_next)
    );

    typedef struct packed {
        logic [1:0]       d;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      sig;
        logic             seq;
        logic             fev;
        logic [IDX_W-1:0] fei;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb [$];

    int total = 0;
    int bad   = 0;

    logic [CNT_W-1:0] m_cnt;
    logic [IDX_W-1:0] m_exp, m_fei;
    logic             m_seq, m_fev;
    int unsigned      m_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int unsigned len_of(input int d);
        return (d == 0) ? 16384 : (d == 1) ? 1 : 4;
    endfunction

    function automatic logic [VEC_W-1:0] decvec(input logic [IDX_W-1:0] idx);
        logic [VEC_W-1:0] v;
        v = '0;
        v[idx[5:0]] = 1'b1;
        v[64 + (int'(idx[13:6]) % 66)] = 1'b1;
        return v;
    endfunction

    task automatic drive(input int d, input logic v, input logic [IDX_W-1:0] idx,
                         input logic [VEC_W-1:0] vec);
        case (d)
            0: begin b0.in_valid = v; b0.in_idx = idx; b0.in_vec = vec; end
            1: begin b1.in_valid = v; b1.in_idx = idx; b1.in_vec = vec; end
            default: begin b4.in_valid = v; b4.in_idx = idx; b4.in_vec = vec; end
        endcase
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? b0.in_ready : (d == 1) ? b1.in_ready : b4.in_ready;
    endfunction

    task automatic model_clear(input int d);
        m_sig = SIG_SEED;
        m_cnt = '0;
        m_exp = '0;
        m_seq = 1'b0;
        m_fev = 1'b0;
        m_fei = '0;
        m_len = len_of(d);
    endtask

    task automatic do_start(input int d);
        @(negedge CLK);
        st[d] = 1'b1;
        @(posedge CLK);
        #1;
        st[d] = 1'b0;
        model_clear(d);
    endtask

    // Offer one beat for one cycle; exp_rdy states whether the DUT should take it
    task automatic beat(input int d, input logic [IDX_W-1:0] idx,
                        input logic [VEC_W-1:0] vec, input logic exp_rdy);
        exp_t e;
        @(negedge CLK);
        drive(d, 1'b1, idx, vec);
        cur_idx = idx;
        cur_vec = vec;
        #1;
        chk("in_ready", 32'(rdy(d)), 32'(exp_rdy));
        if (rdy(d)) begin
            m_cnt = m_cnt + CNT_W'(1);
            if (idx !== m_exp) begin
                m_seq = 1'b1;
                if (FE_EN && !m_fev) begin
                    m_fev = 1'b1;
                    m_fei = m_exp;
                end
            end
            m_exp = m_exp + IDX_W'(1);
            m_sig = m_next;
            e.d    = 2'(d);
            e.cnt  = m_cnt;
            e.sig  = m_sig;
            e.seq  = m_seq;
            e.fev  = m_fev;
            e.fei  = m_fei;
            e.done = (32'(m_cnt) == m_len);
            e.busy = !e.done;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        drive(d, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: an accepted beat at a rising edge is checked at the next falling edge
    initial begin
        logic [2:0] acc;
        exp_t e;
        forever begin
            @(posedge CLK);
            acc = {b4.in_valid & b4.in_ready, b1.in_valid & b1.in_ready,
                   b0.in_valid & b0.in_ready} & {3{~RES}};
            @(negedge CLK);
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: dut %0d accepted a beat with nothing expected", i);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_dut",   32'(i),      32'(e.d));
                        chk("sb_count", 32'(cnt[i]), 32'(e.cnt));
                        chk("sb_sig",   sig[i],      e.sig);
                        chk("sb_seq",   32'(seq[i]), 32'(e.seq));
                        chk("sb_fev",   32'(fev[i]), 32'(e.fev));
                        chk("sb_fei",   32'(fei[i]), 32'(e.fei));
                        chk("sb_busy",  32'(busy[i]), 32'(e.busy));
                        chk("sb_done",  32'(done[i]), 32'(e.done));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        RES = 1'b1;
        st  = '0;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        cur_idx = '0;
        cur_vec = '0;
        model_clear(0);

        // Reset state on all instances
        repeat (2) @(posedge CLK);
        #1;
        RES = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",  32'(busy[i]), 32'd0);
            chk("rst_done",  32'(done[i]), 32'd0);
            chk("rst_seq",   32'(seq[i]),  32'd0);
            chk("rst_count", 32'(cnt[i]),  32'd0);
            chk("rst_sig",   sig[i],       32'hFFFF_FFFF);
            chk("rst_fei",   32'(fei[i]),  32'd0);
            chk("rst_fev",   32'(fev[i]),  32'd0);
            chk("rst_ready", 32'(rdy(i)),  32'd0);
        end

        // SWEEP_LEN=1: single zero beat
        do_start(1);
        beat(1, 14'd0, '0, 1'b1);
        chk("len1_sig",   sig[1],       32'hFB3E_E249);
        chk("len1_count", 32'(cnt[1]),  32'd1);
        chk("len1_done",  32'(done[1]), 32'd1);
        chk("len1_busy",  32'(busy[1]), 32'd0);
        chk("len1_seq",   32'(seq[1]),  32'd0);
        idle(3);
        beat(1, 14'd1, decvec(14'd1), 1'b0);
        chk("len1_hold_count", 32'(cnt[1]),  32'd1);
        chk("len1_hold_done",  32'(done[1]), 32'd1);
        chk("len1_hold_sig",   sig[1],       32'hFB3E_E249);

        // SWEEP_LEN=4: indices 0,1,3,3
        do_start(2);
        beat(2, 14'd0, decvec(14'd0), 1'b1);
        beat(2, 14'd1, decvec(14'd1), 1'b1);
        chk("oo_seq_before", 32'(seq[2]), 32'd0);
        beat(2, 14'd3, decvec(14'd3), 1'b1);
        chk("oo_seq3", 32'(seq[2]), 32'd1);
        chk("oo_fev3", 32'(fev[2]), FE_EN ? 32'd1 : 32'd0);
        chk("oo_fei3", 32'(fei[2]), FE_EN ? 32'd2 : 32'd0);
        beat(2, 14'd3, decvec(14'd3), 1'b1);
        chk("oo_seq4",  32'(seq[2]),  32'd1);
        chk("oo_fev4",  32'(fev[2]),  FE_EN ? 32'd1 : 32'd0);
        chk("oo_fei4",  32'(fei[2]),  FE_EN ? 32'd2 : 32'd0);
        chk("oo_done4", 32'(done[2]), 32'd1);

        // Restart mid-sweep with a beat offered alongside start
        do_start(2);
        beat(2, 14'd0, decvec(14'd0), 1'b1);
        beat(2, 14'd1, decvec(14'd1), 1'b1);
        @(negedge CLK);
        st[2] = 1'b1;
        drive(2, 1'b1, 14'd2, decvec(14'd2));
        #1;
        chk("restart_ready", 32'(rdy(2)), 32'd0);
        @(posedge CLK);
        #1;
        st[2] = 1'b0;
        drive(2, 1'b0, '0, '0);
        model_clear(2);
        chk("restart_count", 32'(cnt[2]),  32'd0);
        chk("restart_sig",   sig[2],       32'hFFFF_FFFF);
        chk("restart_busy",  32'(busy[2]), 32'd1);
        chk("restart_seq",   32'(seq[2]),  32'd1 - 32'd1);
        for (int i = 0; i < 4; i++) beat(2, 14'(i), decvec(14'(i)), 1'b1);
        chk("restart_done", 32'(done[2]), 32'd1);
        chk("restart_fin_seq", 32'(seq[2]), 32'd0);

        // Full default-length sweep with random valid gaps
        do_start(0);
        for (int i = 0; i < 16384; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            beat(0, 14'(i), decvec(14'(i)), 1'b1);
        end
        idle(2);
        chk("full_done",  32'(done[0]), 32'd1);
        chk("full_count", 32'(cnt[0]),  32'd16384);
        chk("full_seq",   32'(seq[0]),  32'd0);
        chk("full_sig",   sig[0],       m_sig);
        beat(0, 14'd5, decvec(14'd5), 1'b0);
        chk("full_hold_count", 32'(cnt[0]), 32'd16384);

        // Reset in the middle of a sweep
        do_start(0);
        for (int i = 0; i < 100; i++) beat(0, 14'(i), decvec(14'(i)), 1'b1);
        chk("mid_count", 32'(cnt[0]), 32'd100);
        @(negedge CLK);
        RES = 1'b1;
        @(posedge CLK);
        #1;
        RES = 1'b0;
        chk("midrst_busy",  32'(busy[0]), 32'd0);
        chk("midrst_done",  32'(done[0]), 32'd0);
        chk("midrst_count", 32'(cnt[0]),  32'd0);
        chk("midrst_sig",   sig[0],       32'hFFFF_FFFF);
        beat(0, 14'd100, decvec(14'd100), 1'b0);
        beat(0, 14'd101, decvec(14'd101), 1'b0);
        chk("midrst_ign_count", 32'(cnt[0]),  32'd0);
        chk("midrst_ign_busy",  32'(busy[0]), 32'd0);

        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_sweep_checker.md
DECODER_SWEEP_CHECKER -- requirements
Module: decoder_sweep_checker

Interface
REQ-001 Parameter SWEEP_LEN, default 16384, sets the number of beats per sweep; the legal range SHALL be 1..16384.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RES  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  a one-cycle pulse that begins or restarts a sweep.
REQ-005 in_valid  input  1  a beat is offered.
REQ-006 in_ready  output  1  the checker accepts a beat.
REQ-007 in_idx  input  14  decoder input index of the beat (T bits [5:0], IR [13:6]).
REQ-008 in_vec  input  130  decoder output vector X for that index.
REQ-009 busy  output  1  a sweep is in progress.
REQ-010 done  output  1  the sweep has completed; held until the next start or RES.
REQ-011 seq_err  output  1  sticky flag: an out-of-order index was seen in the current sweep.
REQ-012 count  output  15  number of beats accepted in the current sweep.
REQ-013 signature  output  32  MISR signature of the current sweep.
REQ-014 first_err_idx  output  14  expected index at the first sequence error (see Configuration).
REQ-015 first_err_valid  output  1  first_err_idx holds a captured value.

Function
REQ-016 The state machine SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-017 busy SHALL equal (state==RUN), done SHALL equal (state==DONE), and in_ready SHALL equal (state==RUN) & ~start.
REQ-018 Transitions: start in any state moves to RUN; in RUN, the accepted beat that makes count reach SWEEP_LEN moves to DONE; no other transitions exist.
REQ-019 Entry into RUN via start SHALL clear count, the expected index, seq_err, first_err_valid and first_err_idx, and SHALL set signature to 32'hFFFFFFFF.
REQ-020 A beat SHALL be accepted only on a cycle with in_valid & in_ready; a beat offered in the same cycle as start SHALL be discarded.
REQ-021 On an accepted beat where in_idx != expected, seq_err SHALL be set; the expected index SHALL then advance as expected+1 regardless of in_idx.
REQ-022 The expected index SHALL be 14 bits wide, start at 0 and wrap from 16383 to 0.
REQ-023 Fold: fold = in_vec[31:0] ^ in_vec[63:32] ^ in_vec[95:64] ^ in_vec[127:96] ^ {in_vec[129:128], 16'h0, in_idx}.
REQ-024 On each accepted beat, signature SHALL update to {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-025 count SHALL increment by exactly 1 per accepted beat, so the result of every accepted beat is visible on the following cycle (latency 1).
REQ-026 In IDLE and DONE, in_valid SHALL be ignored, and count, signature and seq_err SHALL hold their values.

Reset
REQ-027 When RES=1 at a clock edge, the outputs SHALL become state=IDLE, busy=0, done=0, seq_err=0, count=0, signature=32'hFFFFFFFF, first_err_idx=0 and first_err_valid=0.
REQ-028 RES SHALL take priority over start and over a beat in the same cycle; RES in the middle of a sweep SHALL abandon it.

Configuration
REQ-029 With macro DSC_FIRST_ERR_EN defined, the first accepted beat that sets seq_err SHALL load first_err_idx with the expected index and set first_err_valid; later errors in the same sweep SHALL NOT overwrite either.
REQ-030 Without DSC_FIRST_ERR_EN, first_err_idx and first_err_valid SHALL be constant 0, and no capture logic SHALL be synthesized.

Structure
REQ-031 The shared package dsc_pkg SHALL hold the state enumeration, SIG_SEED=32'hFFFFFFFF, SIG_POLY=32'h04C11DB7, IDX_W=14 and VEC_W=130.
REQ-032 The fold and LFSR-step logic SHALL be one combinational sub-module, dsc_misr_step, which is reused by the bench model.

Verification
REQ-033 Reset: RES high for 2 cycles, then low -> the outputs match REQ-027 and in_ready=0.
REQ-034 With SWEEP_LEN=1, start, then one beat (idx=0, vec=0) -> on the next cycle signature=32'hFB3EE249, count=1, done=1, busy=0, seq_err=0.
REQ-035 With the default SWEEP_LEN, start, then 16384 in-order beats from the decoder enumeration with random in_valid gaps -> done=1, count=16384, seq_err=0, and signature equals the dsc_misr_step model.
REQ-036 SWEEP_LEN=4, beats with idx 0,1,3,3 -> seq_err=1 from the third beat onward; with DSC_FIRST_ERR_EN, first_err_idx=2 and first_err_valid=1, and the fourth beat leaves both unchanged.
REQ-037 start asserted in the same cycle as an offered beat in the middle of a sweep -> the beat is discarded, count=0 and signature=32'hFFFFFFFF on the next cycle, and busy=1.
REQ-038 RES pulsed in the middle of a sweep with count=100 -> IDLE on the next cycle, count=0, and later beats are ignored until start.
